// File: rtl/div_share_ctrl.sv
// div_share_ctrl: lets NREQ clients take turns on one combinational divider.
// Requests are granted round-robin and the operands are latched. The divider
// is then given DIV_CYCLES cycles to settle before its result is registered
// and returned on a single tagged valid/ready response channel.

// Combinational restoring divider. A zero divisor returns a value that is not
// meaningful; the controller substitutes its own result for that case.
module divider #(
    parameter int DIVIDEND = 6,
    parameter int DIVISOR  = 3
) (
    input  logic [DIVIDEND-1:0] dividend,
    input  logic [DIVISOR-1:0]  divisor,
    output logic [DIVIDEND-1:0] quotient,
    output logic [DIVISOR-1:0]  remainder
);

    logic [DIVISOR:0] rem_s;

    // Shift-subtract long division, most significant dividend bit first.
    always_comb begin
        rem_s    = '0;
        quotient = '0;
        for (int i = DIVIDEND - 1; i >= 0; i--) begin
            rem_s = {rem_s[DIVISOR-1:0], dividend[i]};
            if (rem_s >= {1'b0, divisor}) begin
                rem_s       = rem_s - {1'b0, divisor};
                quotient[i] = 1'b1;
            end else begin
                quotient[i] = 1'b0;
            end
        end
        remainder = rem_s[DIVISOR-1:0];
    end

endmodule

module div_share_ctrl #(
    parameter int  DIVIDEND   = 6,
    parameter int  DIVISOR    = 3,
    parameter int  NREQ       = 2,
    parameter int  DIV_CYCLES = 2,
    localparam int ID_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DIVIDEND-1:0] req_dividend,
    input  logic [NREQ*DIVISOR-1:0]  req_divisor,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DIVIDEND-1:0]      rsp_quotient,
    output logic [DIVISOR-1:0]       rsp_remainder,
    output logic                     rsp_dz
);

    // The settle counter only ever holds values 0 .. DIV_CYCLES-1.
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester index that is 'off' positions after 'base', wrapping at NREQ.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NREQ;
        return ID_W'(sum);
    endfunction

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND-1:0]   op_a_q, op_a_d;
    logic [DIVISOR-1:0]    op_b_q, op_b_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DIVIDEND-1:0]   rsp_quo_q, rsp_quo_d;
    logic [DIVISOR-1:0]    rsp_rem_q, rsp_rem_d;
    logic                  rsp_dz_q, rsp_dz_d;

    logic                  gnt_found_s;
    logic [ID_W-1:0]       gnt_idx_s;
    logic [NREQ-1:0]       req_ready_s;
    logic                  accept_s;
    logic [DIVIDEND-1:0]   div_quo_s;
    logic [DIVISOR-1:0]    div_rem_s;

    // Shared divider always sees the latched operands, so its inputs are
    // stable for the whole settle window.
    divider #(
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR)
    ) u_divider (
        .dividend  (op_a_q),
        .divisor   (op_b_q),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Round-robin search: first valid requester at or after ptr_q wins.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found_s && req_valid[rr_idx(ptr_q, k)]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = rr_idx(ptr_q, k);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // One-hot accept to the granted requester, only while idle and out of reset.
    always_comb begin
        req_ready_s = '0;
        if ((state_q == ST_IDLE) && gnt_found_s && !reset) begin
            req_ready_s[gnt_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign accept_s  = |(req_valid & req_ready_s);
    assign req_ready = req_ready_s;

    // Next-state logic: accept in IDLE, count down in WAIT, hand off in RESP.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_quo_d   = rsp_quo_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_dz_d    = rsp_dz_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_a_d  = req_dividend[int'(gnt_idx_s)*DIVIDEND +: DIVIDEND];
                    op_b_d  = req_divisor[int'(gnt_idx_s)*DIVISOR +: DIVISOR];
                    id_d    = gnt_idx_s;
                    ptr_d   = rr_idx(gnt_idx_s, 1);
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_WAIT;
                end else begin
                    // Divider has had its full settle time; register the result.
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    state_d     = ST_RESP;
                    if (op_b_q == {DIVISOR{1'b0}}) begin
                        rsp_quo_d = {DIVIDEND{1'b1}};
                        rsp_rem_d = {DIVISOR{1'b0}};
                        rsp_dz_d  = 1'b1;
                    end else begin
                        rsp_quo_d = div_quo_s;
                        rsp_rem_d = div_rem_s;
                        rsp_dz_d  = 1'b0;
                    end
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    // Data registers keep their last values after the handoff.
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quo_q   <= '0;
            rsp_rem_q   <= '0;
            rsp_dz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quo_q   <= rsp_quo_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_dz_q    <= rsp_dz_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quo_q;
    assign rsp_remainder = rsp_rem_q;
    assign rsp_dz        = rsp_dz_q;

endmodule
